// File: rtl/stroke_sequencer.sv
// Walks an external combinational stroke ROM for one glyph and hands out shrunk, offset and
// saturated segments one at a time over a valid/ready handshake.
module stroke_sequencer #(
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned MAX_STROKES = 16,
  parameter int unsigned NUM_GLYPHS  = 10,
  parameter int unsigned GLYPH_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [GLYPH_W-1:0] glyph,
  input  logic [1:0]         shrink,
  input  logic [COORD_W-1:0] off_x,
  input  logic [COORD_W-1:0] off_y,
  input  logic               abort,
  output logic [GLYPH_W-1:0] rom_glyph,
  output logic [IDX_W-1:0]   rom_idx,
  input  logic [COORD_W-1:0] rom_sx,
  input  logic [COORD_W-1:0] rom_sy,
  input  logic [COORD_W-1:0] rom_ex,
  input  logic [COORD_W-1:0] rom_ey,
  input  logic               rom_pen,
  input  logic               rom_last,
  output logic               seg_valid,
  input  logic               seg_ready,
  output logic [COORD_W-1:0] seg_sx,
  output logic [COORD_W-1:0] seg_sy,
  output logic [COORD_W-1:0] seg_ex,
  output logic [COORD_W-1:0] seg_ey,
  output logic               seg_pen,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MAX_STROKES - 1);

  state_e             state_q;
  logic [1:0]         shrink_q;
  logic [COORD_W-1:0] off_x_q;
  logic [COORD_W-1:0] off_y_q;
  logic               last_q;
  logic               glyph_ok;

  assign glyph_ok = 32'(glyph) < NUM_GLYPHS;

  // Shift, then add one bit wider so a carry out clamps to full scale.
  function automatic logic [COORD_W-1:0] xform(input logic [COORD_W-1:0] c,
                                               input logic [1:0]         sh,
                                               input logic [COORD_W-1:0] off);
    logic [COORD_W:0] sum;
    sum = {1'b0, c >> sh} + {1'b0, off};
    return sum[COORD_W] ? '1 : sum[COORD_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shrink_q  <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      last_q    <= 1'b0;
      rom_glyph <= '0;
      rom_idx   <= '0;
      seg_valid <= 1'b0;
      seg_sx    <= '0;
      seg_sy    <= '0;
      seg_ex    <= '0;
      seg_ey    <= '0;
      seg_pen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (glyph_ok) begin
              rom_glyph <= glyph;
              shrink_q  <= shrink;
              off_x_q   <= off_x;
              off_y_q   <= off_y;
              rom_idx   <= '0;
              busy      <= 1'b1;
              state_q   <= StFetch;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StFetch: begin
          seg_sx    <= xform(rom_sx, shrink_q, off_x_q);
          seg_sy    <= xform(rom_sy, shrink_q, off_y_q);
          seg_ex    <= xform(rom_ex, shrink_q, off_x_q);
          seg_ey    <= xform(rom_ey, shrink_q, off_y_q);
          seg_pen   <= rom_pen;
          last_q    <= rom_last || (rom_idx == LastIdx);
          seg_valid <= 1'b1;
          state_q   <= StEmit;
        end
        StEmit: begin
          if (seg_ready) begin
            seg_valid <= 1'b0;
            if (last_q) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              rom_idx <= rom_idx + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
      // Abort wins over any handshake or completion in the same cycle.
      if (abort && (state_q != StIdle)) begin
        state_q   <= StIdle;
        seg_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stroke_sequencer.md
Name: stroke_sequencer

Overview:
- Parametrised successor to the per-digit stroke tables: walks an external combinational stroke ROM for a selected glyph and issues one transformed segment at a time to the line-drawing engine.
- Valid/ready handshake on the output side; per-job shrink and offset; abort; end-of-glyph detection.
- Sits between the glyph/job controller and the plotter motion engine.

Parameters:
- COORD_W, 8, coordinate width for ROM, offset and output coordinates.
- IDX_W, 5, stroke index width; also sets the ROM address width.
- MAX_STROKES, 16, hard stroke limit per glyph; 1..2^IDX_W.
- NUM_GLYPHS, 10, number of valid glyph codes; valid codes are 0..NUM_GLYPHS-1.
- GLYPH_W, 4, glyph select width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- glyph  in  GLYPH_W  glyph code; captured on accepted start.
- shrink  in  2  right-shift applied to ROM coordinates; captured on accepted start.
- off_x, off_y  in  COORD_W  origin offset; captured on accepted start.
- abort  in  1  synchronous cancel of the current job.
- rom_glyph  out  GLYPH_W  ROM glyph select.
- rom_idx  out  IDX_W  ROM stroke index.
- rom_sx, rom_sy, rom_ex, rom_ey  in  COORD_W  combinational ROM stroke endpoints.
- rom_pen  in  1  ROM pen_down flag.
- rom_last  in  1  ROM flag: this stroke is the final stroke of the glyph.
- seg_valid  out  1  segment available.
- seg_ready  in  1  drawing engine accepts the segment.
- seg_sx, seg_sy, seg_ex, seg_ey  out  COORD_W  transformed segment endpoints.
- seg_pen  out  1  pen down for this segment.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a job completes normally.
- err  out  1  one-cycle pulse when start is given with an invalid glyph.

Behaviour:
- Reset: state=IDLE; rom_idx, rom_glyph, all seg_* coordinates, seg_pen, seg_valid, busy, done and err are 0; captured job registers are 0.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE, start=1, glyph<NUM_GLYPHS: capture glyph, shrink, off_x and off_y; set rom_idx=0; go to FETCH.
- IDLE, start=1, glyph>=NUM_GLYPHS: err=1 for one cycle; stay in IDLE; no ROM activity is meaningful.
- FETCH (one cycle): rom_glyph/rom_idx are stable. Register the transformed outputs:
  - seg_sx = sat((rom_sx >> shrink) + off_x), computed at COORD_W+1 bits.
  - sat clamps to 2^COORD_W-1. seg_sy, seg_ex and seg_ey follow the same rule.
  - seg_pen = rom_pen.
  - last_r = rom_last OR (rom_idx == MAX_STROKES-1).
  - Go to EMIT.
- EMIT: seg_valid=1. The seg_* outputs are held constant until the handshake (seg_valid & seg_ready).
  - On handshake, last_r=1: go to DONE.
  - On handshake, last_r=0: rom_idx+1, go to FETCH.
  - seg_ready=1 before EMIT has no effect.
- DONE: done=1 for one cycle; go to IDLE. seg_valid=0. seg_* keep their last values.
- Latency: accepted start to first seg_valid = 2 cycles. Handshake to next seg_valid = 2 cycles, so the maximum rate is one segment per 2 cycles.
- abort=1 in FETCH, EMIT or DONE forces IDLE on the next edge.
  - seg_valid drops, and no done pulse is issued.
  - abort overrides a simultaneous handshake: that segment counts as consumed, and no further segments follow.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start is accepted.
- start while busy is ignored; job parameters cannot change mid-job.
- rom_idx never wraps: MAX_STROKES-1 always terminates the job.
- Asynchronous reset mid-job returns everything to reset values immediately.

Test Plan:
- Glyph 3 from a 3-stroke ROM, strokes (0,0→60,40,pen 0), (60,40→60,120,pen 1), (60,120→120,120,pen 1,last); shrink=0, off=0; seg_ready held 1 -> exactly 3 handshakes with those values in order; seg_valid at cycles 2, 4, 6 after start; done one cycle after the third handshake.
- Same glyph, shrink=1, off_x=10, off_y=5 -> second segment is (40,25→40,65).
- Stroke (180,40→200,120), shrink=0, off_x=100 -> seg_sx=255 and seg_ex=255 (saturated); seg_sy=40, seg_ey=120.
- seg_ready held 0 for 5 cycles in EMIT -> seg_valid stays 1 and seg_* are unchanged; seg_ready=1 then advances.
- ROM with no rom_last, MAX_STROKES=4 -> exactly 4 segments, then done.
- glyph=12 with start -> err pulse, busy stays 0. abort during the second EMIT -> IDLE next cycle, seg_valid=0, no done pulse.
